ahblite_rtc: RTL

// AHB-Lite slave real-time clock for the desk clock: hour/minute/second counters from HCLK via a prescaler,
// one alarm comparator with interrupt. Sits on one slave port of the AHB slave response mux.
// Its HREADYOUT/HRESP/HRDATA drive one Px_* input of that mux.

---
 rtl/ahblite_rtc.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/ahblite_rtc.sv
// AHB-Lite real-time clock slave for the desk clock.
// Keeps hours/minutes/seconds that advance once per TICK_DIV HCLK cycles while
// running. One alarm comparator raises a sticky flag and a level interrupt.
// Legal word accesses complete with zero wait states. Illegal accesses get the
// two-cycle AHB ERROR response and change no register.
//
// Response FSM
//   state  | meaning
//   S_IDLE | OKAY response, HREADYOUT=1
//   S_ERR1 | first ERROR cycle, HREADYOUT=0 HRESP=1
//   S_ERR2 | second ERROR cycle, HREADYOUT=1 HRESP=1
module ahblite_rtc #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic        IRQ
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [31:0] ID_VALUE = 32'h5254_4301;

  localparam logic [2:0] OFF_CTRL  = 3'd0;
  localparam logic [2:0] OFF_TIME  = 3'd1;
  localparam logic [2:0] OFF_ALARM = 3'd2;
  localparam logic [2:0] OFF_STAT  = 3'd3;
  localparam logic [2:0] OFF_ID    = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ERR1 = 2'd1,
    S_ERR2 = 2'd2
  } resp_state_e;

  resp_state_e state_q;
  logic        hreadyout_q;
  logic        hresp_q;

  logic        dp_valid_q;
  logic        dp_write_q;
  logic [2:0]  dp_off_q;

  logic        run_q;
  logic        irq_en_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]  sec_q, sec_d;
  logic [5:0]  min_q, min_d;
  logic [4:0]  hour_q, hour_d;
  logic [5:0]  al_sec_q;
  logic [5:0]  al_min_q;
  logic [4:0]  al_hour_q;
  logic        flag_q, flag_d;
  logic        irq_q;

  logic        addr_accept;
  logic        addr_legal;
  logic        wr_en;
  logic        rd_en;
  logic        wr_ctrl, wr_time, wr_alarm, wr_stat;
  logic        tick;
  logic        alarm_hit;
  logic [5:0]  wsec, wmin;
  logic [4:0]  whour;
  logic [5:0]  sec_inc, min_inc;
  logic [4:0]  hour_inc;
  logic        carry_s, carry_m;
  logic [31:0] time_word;
  logic [31:0] alarm_word;
  logic        unused_ok;

  // Address-phase decode; HADDR[4:2] offsets 5..7 fall outside the map.
  assign addr_accept = HSEL & HREADY & HTRANS[1];
  assign addr_legal  = (HADDR[4:2] <= OFF_ID) && (HSIZE == 3'b010);

  assign wr_en    = dp_valid_q & dp_write_q & HREADY;
  assign rd_en    = dp_valid_q & ~dp_write_q;
  assign wr_ctrl  = wr_en && (dp_off_q == OFF_CTRL);
  assign wr_time  = wr_en && (dp_off_q == OFF_TIME);
  assign wr_alarm = wr_en && (dp_off_q == OFF_ALARM);
  assign wr_stat  = wr_en && (dp_off_q == OFF_STAT);

  // Out-of-range fields are stored as zero rather than saturated.
  assign wsec  = (HWDATA[5:0]   > 6'd59) ? 6'd0 : HWDATA[5:0];
  assign wmin  = (HWDATA[13:8]  > 6'd59) ? 6'd0 : HWDATA[13:8];
  assign whour = (HWDATA[20:16] > 5'd23) ? 5'd0 : HWDATA[20:16];

  assign tick = run_q && (presc_q == PRESC_LAST);

  assign time_word  = {11'd0, hour_q, 2'd0, min_q, 2'd0, sec_q};
  assign alarm_word = {11'd0, al_hour_q, 2'd0, al_min_q, 2'd0, al_sec_q};

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign IRQ       = irq_q;

  assign unused_ok = ^{HADDR[31:5], HADDR[1:0], HTRANS[0],
                       HWDATA[31:21], HWDATA[15:14], HWDATA[7:6]};

  // Response FSM with registered HREADYOUT/HRESP.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ERR2: begin
          if (addr_accept && !addr_legal) begin
            state_q     <= S_ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= 1'b1;
          end else begin
            state_q     <= S_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
        S_ERR1: begin
          state_q     <= S_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b0;
        end
      endcase
    end
  end

  // Data-phase capture; only legal transfers open a data phase that touches registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_off_q   <= 3'd0;
    end else if (HREADY) begin
      dp_valid_q <= addr_accept & addr_legal;
      dp_write_q <= HWRITE;
      dp_off_q   <= HADDR[4:2];
    end
  end

  // Control register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      run_q    <= 1'b0;
      irq_en_q <= 1'b0;
    end else if (wr_ctrl) begin
      run_q    <= HWDATA[0];
      irq_en_q <= HWDATA[1];
    end
  end

  // Post-tick time value with sec -> min -> hour carries; wraps at 23:59:59.
  always_comb begin
    carry_s  = (sec_q == 6'd59);
    carry_m  = carry_s && (min_q == 6'd59);
    sec_inc  = carry_s ? 6'd0 : sec_q + 6'd1;
    min_inc  = min_q;
    hour_inc = hour_q;
    if (carry_s) begin
      min_inc = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
    end
    if (carry_m) begin
      hour_inc = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
    end
  end

  // Next prescaler/time; a TIME write beats a coincident tick and restarts the second.
  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    if (wr_time) begin
      presc_d = '0;
      sec_d   = wsec;
      min_d   = wmin;
      hour_d  = whour;
    end else if (tick) begin
      presc_d = '0;
      sec_d   = sec_inc;
      min_d   = min_inc;
      hour_d  = hour_inc;
    end else if (run_q) begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Prescaler and time-of-day registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      presc_q <= '0;
      sec_q   <= 6'd0;
      min_q   <= 6'd0;
      hour_q  <= 5'd0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
    end
  end

  // Alarm compare register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      al_sec_q  <= 6'd0;
      al_min_q  <= 6'd0;
      al_hour_q <= 5'd0;
    end else if (wr_alarm) begin
      al_sec_q  <= wsec;
      al_min_q  <= wmin;
      al_hour_q <= whour;
    end
  end

  // Alarm matches only on a tick that actually advances time.
  assign alarm_hit = tick && !wr_time &&
                     ({hour_inc, min_inc, sec_inc} == {al_hour_q, al_min_q, al_sec_q});

  // Sticky flag: a new hit outranks a simultaneous write-1-to-clear.
  always_comb begin
    flag_d = flag_q;
    if (alarm_hit) begin
      flag_d = 1'b1;
    end else if (wr_stat && HWDATA[0]) begin
      flag_d = 1'b0;
    end
  end

  // Alarm flag and registered interrupt (lags the flag by one cycle).
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      flag_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      irq_q  <= flag_q & irq_en_q;
    end
  end

  // Read data mux driven from the latched data-phase offset.
  always_comb begin
    HRDATA = 32'd0;
    if (rd_en) begin
      case (dp_off_q)
        OFF_CTRL:  HRDATA = {30'd0, irq_en_q, run_q};
        OFF_TIME:  HRDATA = time_word;
        OFF_ALARM: HRDATA = alarm_word;
        OFF_STAT:  HRDATA = {31'd0, flag_q};
        OFF_ID:    HRDATA = ID_VALUE;
        default:   HRDATA = 32'd0;
      endcase
    end
  end

endmodule
